on_off_sender: RTL and testbench
================================

ON_OFF_SENDER -- requirements
Module: on_off_sender

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 4, staging FIFO depth in flits (power of two, >=2).
REQ-002 SHALL have parameter ON_OFF_LATENCY, default 4, downstream on/off headroom; equals the value used by the downstream input buffer.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  reset, asynchronous, active-high
  data_i  in  flit_t  flit from switch traversal
  valid_i  in  1  data_i valid, push request
  ready_o  out  1  staging FIFO can accept a flit
  on_off_i  in  1  downstream on/off flag; 1 = on (may send)
  data_o  out  flit_t  flit on link to downstream buffer
  valid_o  out  1  link write strobe (drives downstream write_i)
  state_o  out  2  FSM state: 0 IDLE, 1 ACTIVE, 2 HALTED
  stall_cnt_o  out  16  cycles a flit waited while halted, saturating

Function
REQ-004 SHALL register on_off_i into on_off_q every cycle; all send decisions use on_off_q only (one-cycle sample delay, covered by ON_OFF_LATENCY headroom).
REQ-005 SHALL push data_i into the staging FIFO at a rising edge iff valid_i=1 and ready_o=1; valid_i with ready_o=0 is dropped and has no effect.
REQ-006 SHALL drive ready_o = 1 iff FIFO occupancy < BUFFER_SIZE, derived from registered state only (no combinational path from valid_i or on_off_i).
REQ-007 SHALL pop the FIFO head at a rising edge iff FIFO non-empty and on_off_q=1 (send event); at most one flit per cycle.
REQ-008 SHALL register outputs: after a send event, valid_o=1 and data_o=popped flit for exactly the following cycle; otherwise valid_o=0 next cycle and data_o holds its last value.
REQ-009 SHALL keep send latency of 1 cycle: a flit pushed into an empty FIFO with on_off_q=1 at edge N appears on data_o with valid_o=1 after edge N+1.
REQ-010 SHALL permit simultaneous push and pop in one cycle; occupancy unchanged; flit order strictly FIFO.
REQ-011 SHALL wrap read and write pointers from BUFFER_SIZE-1 to 0; occupancy counter is log2(BUFFER_SIZE)+1 bits.
REQ-012 SHALL never assert valid_o in a cycle following an edge where on_off_q was 0.
REQ-013 SHALL compute next FSM state each edge from next occupancy and next on_off_q: HALTED if on_off_q'=0 and occupancy'>0; else ACTIVE if occupancy'>0; else IDLE.
REQ-014 SHALL increment stall_cnt_o at each edge where state_o=HALTED, saturating at 16'hFFFF; never decremented except by reset.
REQ-015 SHALL, when on_off_q returns to 1 in HALTED, resume sending on the next edge with the oldest waiting flit first.
REQ-016 SHALL, in IDLE with on_off_q=0, accept pushes up to BUFFER_SIZE and transition to HALTED.

Reset
REQ-017 SHALL on rst=1, independent of clk, set: pointers and occupancy 0, on_off_q=1, valid_o=0, data_o=0, ready_o=1, state_o=IDLE, stall_cnt_o=0.
REQ-018 SHALL discard all staged flits on reset mid-operation; no flit sent after reset until a new push.
REQ-019 SHALL leave FIFO storage contents unreset; only pointers define validity.

Verification
REQ-020 Basic send: reset, on_off_i=1, push flits A,B,C on consecutive cycles -> valid_o=1 with A,B,C on three consecutive cycles, first one cycle after A pushed; state IDLE->ACTIVE->IDLE.
REQ-021 Halt/fill: on_off_i=0, push 5 flits with BUFFER_SIZE=4 -> 4 accepted, ready_o=0 after 4th, 5th dropped, valid_o=0 throughout, state HALTED, stall_cnt_o increments each cycle.
REQ-022 Resume: from REQ-021 state raise on_off_i=1 -> after 2 edges valid_o=1 with 1st flit, 4 flits in order on consecutive cycles, ready_o=1 after first pop.
REQ-023 Off mid-burst: 4 flits staged, on_off_i drops after 2nd send -> at most one more flit sent (sample delay), remainder held until on_off_i=1.
REQ-024 Full wrap and simultaneous push/pop: continuous valid_i=1, on_off_i=1 for 3*BUFFER_SIZE flits -> all delivered in order, pointers wrap, no drops.
REQ-025 Async reset: assert rst mid-burst between clock edges -> valid_o=0, ready_o=1, state_o=0, stall_cnt_o=0 immediately; staged flits never appear on data_o.

Source files
------------

// File: rtl/on_off_sender.sv
// ============================================================================
// Module      : on_off_sender
// Description : Link sender with staging FIFO, gated by downstream on/off flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module on_off_sender #(
    parameter int BUFFER_SIZE    = 4,
    parameter int ON_OFF_LATENCY = 4,
    parameter int FLIT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              on_off_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              valid_o,
    output logic [1:0]        state_o,
    output logic [15:0]       stall_cnt_o
);

    localparam int            AW    = $clog2(BUFFER_SIZE);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The one-cycle on/off sample delay must fit inside the downstream headroom.
    if ((BUFFER_SIZE < 2) || ((BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) || (ON_OFF_LATENCY < 1))
    begin : g_bad_params
        $error("on_off_sender: invalid BUFFER_SIZE or ON_OFF_LATENCY");
    end

    logic [FLIT_W-1:0] mem_q [BUFFER_SIZE];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              on_off_q, on_off_d;
    logic              valid_q, valid_d;
    logic [FLIT_W-1:0] data_q, data_d;
    state_t            state_q, state_d;
    logic [15:0]       stall_q, stall_d;
    logic              push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            on_off_q <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            state_q  <= ST_IDLE;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            on_off_q <= on_off_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            state_q  <= state_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is deliberately unreset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        push     = valid_i && ready_o;
        pop      = (count_q != '0) && on_off_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        on_off_d = on_off_i;
        valid_d  = pop;
        data_d   = data_q;
        state_d  = ST_IDLE;
        stall_d  = stall_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = mem_q[rd_ptr_q];
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        if (!on_off_d && (count_d != '0)) begin
            state_d = ST_HALTED;
        end else if (count_d != '0) begin
            state_d = ST_ACTIVE;
        end

        if ((state_q == ST_HALTED) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign ready_o     = (count_q < DEPTH);
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_on_off_sender.sv
// ============================================================================
// Module      : tb_on_off_sender
// Description : Directed self-checking bench for on_off_sender (BUFFER_SIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_on_off_sender;

    localparam int BS = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic          on_off_i;
    logic [FW-1:0] data_o;
    logic          valid_o;
    logic [1:0]    state_o;
    logic [15:0]   stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    on_off_sender #(
        .BUFFER_SIZE   (BS),
        .ON_OFF_LATENCY(4),
        .FLIT_W        (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .on_off_i   (on_off_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .state_o    (state_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({valid_o, ready_o, state_o, stall_cnt_o, data_o} !== {1'b0, 1'b1, 2'd0, 16'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b st=%0d stall=%0d d=%h, want v=0 r=1 st=0 stall=0 d=0000",
                     valid_o, ready_o, state_o, stall_cnt_o, data_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic_send;
        logic [FW-1:0] flits [3];
        flits[0] = 16'hA0A0; flits[1] = 16'hB0B0; flits[2] = 16'hC0C0;
        on_off_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = flits[i];
            tick();
            n_cmp++;
            if (i == 0) begin
                if ({valid_o, state_o} !== {1'b0, 2'd1}) begin
                    n_err++;
                    $display("FAIL basic_first: got v=%b st=%0d, want v=0 st=1", valid_o, state_o);
                end
            end else if ({valid_o, data_o, state_o} !== {1'b1, flits[i-1], 2'd1}) begin
                n_err++;
                $display("FAIL basic_send%0d: got v=%b d=%h st=%0d, want v=1 d=%h st=1",
                         i, valid_o, data_o, state_o, flits[i-1]);
            end
        end
        valid_i = 1'b0;
        tick();
        n_cmp++;
        if ({valid_o, data_o, state_o} !== {1'b1, flits[2], 2'd0}) begin
            n_err++;
            $display("FAIL basic_last: got v=%b d=%h st=%0d, want v=1 d=%h st=0", valid_o, data_o, state_o, flits[2]);
        end
        tick();
        n_cmp++;
        if ({valid_o, data_o, state_o} !== {1'b0, flits[2], 2'd0}) begin
            n_err++;
            $display("FAIL basic_idle: got v=%b d=%h st=%0d, want v=0 d=%h st=0", valid_o, data_o, state_o, flits[2]);
        end
    endtask

    task automatic test_halt_fill;
        on_off_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = 16'h0010 + FW'(i);
            tick();
            n_cmp++;
            if ({valid_o, ready_o, state_o, stall_cnt_o} !== {1'b0, (i < 3), 2'd2, 16'(i)}) begin
                n_err++;
                $display("FAIL halt_push%0d: got v=%b r=%b st=%0d stall=%0d, want v=0 r=%b st=2 stall=%0d",
                         i, valid_o, ready_o, state_o, stall_cnt_o, (i < 3), i);
            end
        end
        valid_i = 1'b0;
        tick();
        n_cmp++;
        if ({valid_o, ready_o, state_o, stall_cnt_o} !== {1'b0, 1'b0, 2'd2, 16'd5}) begin
            n_err++;
            $display("FAIL halt_hold: got v=%b r=%b st=%0d stall=%0d, want v=0 r=0 st=2 stall=5",
                     valid_o, ready_o, state_o, stall_cnt_o);
        end
    endtask

    task automatic test_resume;
        on_off_i = 1'b1;
        tick();
        n_cmp++;
        if ({valid_o, ready_o, state_o, stall_cnt_o} !== {1'b0, 1'b0, 2'd1, 16'd6}) begin
            n_err++;
            $display("FAIL resume_sample: got v=%b r=%b st=%0d stall=%0d, want v=0 r=0 st=1 stall=6",
                     valid_o, ready_o, state_o, stall_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({valid_o, data_o, ready_o, state_o, stall_cnt_o} !==
                {1'b1, 16'h0010 + FW'(i), 1'b1, (i == 3) ? 2'd0 : 2'd1, 16'd6}) begin
                n_err++;
                $display("FAIL resume_pop%0d: got v=%b d=%h r=%b st=%0d stall=%0d, want v=1 d=%h r=1 st=%0d stall=6",
                         i, valid_o, data_o, ready_o, state_o, stall_cnt_o, 16'h0010 + FW'(i), (i == 3) ? 0 : 1);
            end
        end
        tick();
        n_cmp++;
        if ({valid_o, state_o} !== {1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL resume_drained: got v=%b st=%0d, want v=0 st=0", valid_o, state_o);
        end
    endtask

    task automatic test_off_mid_burst;
        on_off_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 16'h0020 + FW'(i);
            tick();
        end
        valid_i  = 1'b0;
        on_off_i = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({valid_o, data_o} !== {1'b1, 16'h0020}) begin
            n_err++;
            $display("FAIL midoff_send0: got v=%b d=%h, want v=1 d=0020", valid_o, data_o);
        end
        tick();
        n_cmp++;
        if ({valid_o, data_o} !== {1'b1, 16'h0021}) begin
            n_err++;
            $display("FAIL midoff_send1: got v=%b d=%h, want v=1 d=0021", valid_o, data_o);
        end
        on_off_i = 1'b0;
        tick();
        n_cmp++;
        if ({valid_o, data_o, state_o} !== {1'b1, 16'h0022, 2'd2}) begin
            n_err++;
            $display("FAIL midoff_extra: got v=%b d=%h st=%0d, want v=1 d=0022 st=2", valid_o, data_o, state_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({valid_o, data_o, state_o} !== {1'b0, 16'h0022, 2'd2}) begin
                n_err++;
                $display("FAIL midoff_held%0d: got v=%b d=%h st=%0d, want v=0 d=0022 st=2",
                         i, valid_o, data_o, state_o);
            end
        end
        on_off_i = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({valid_o, data_o, state_o} !== {1'b1, 16'h0023, 2'd0}) begin
            n_err++;
            $display("FAIL midoff_resume: got v=%b d=%h st=%0d, want v=1 d=0023 st=0", valid_o, data_o, state_o);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        on_off_i = 1'b1;
        for (int i = 0; i < 3 * BS; i++) begin
            valid_i = 1'b1;
            data_i  = 16'h0030 + FW'(i);
            tick();
            if (i > 0) begin
                n_cmp++;
                if ({valid_o, data_o, ready_o, state_o} !== {1'b1, 16'h0030 + FW'(i - 1), 1'b1, 2'd1}) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got v=%b d=%h r=%b st=%0d, want v=1 d=%h r=1 st=1",
                             i, valid_o, data_o, ready_o, state_o, 16'h0030 + FW'(i - 1));
                end
            end
        end
        valid_i = 1'b0;
        tick();
        n_cmp++;
        if ({valid_o, data_o, state_o} !== {1'b1, 16'h003B, 2'd0}) begin
            n_err++;
            $display("FAIL b2b_last: got v=%b d=%h st=%0d, want v=1 d=003b st=0", valid_o, data_o, state_o);
        end
        tick();
    endtask

    task automatic test_async_reset;
        on_off_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            data_i  = 16'h0040 + FW'(i);
            tick();
        end
        data_i = 16'h0042;
        tick();
        n_cmp++;
        if ({valid_o, data_o} !== {1'b1, 16'h0041}) begin
            n_err++;
            $display("FAIL arst_pre: got v=%b d=%h, want v=1 d=0041", valid_o, data_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({valid_o, ready_o, state_o, stall_cnt_o, data_o} !== {1'b0, 1'b1, 2'd0, 16'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL arst_now: got v=%b r=%b st=%0d stall=%0d d=%h, want v=0 r=1 st=0 stall=0 d=0000",
                     valid_o, ready_o, state_o, stall_cnt_o, data_o);
        end
        valid_i = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({valid_o, data_o, state_o, ready_o} !== {1'b0, 16'h0000, 2'd0, 1'b1}) begin
                n_err++;
                $display("FAIL arst_after%0d: got v=%b d=%h st=%0d r=%b, want v=0 d=0000 st=0 r=1",
                         i, valid_o, data_o, state_o, ready_o);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid_i  = 1'b0;
        on_off_i = 1'b1;
        data_i   = '0;
        test_reset();
        test_basic_send();
        test_halt_fill();
        test_resume();
        test_off_mid_burst();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
